// File: rtl/alu_seq.sv
// Purpose: registered ALU with a start/busy/done handshake (ADD/SUB/AND/OR/XOR/SHL/MUL-or-ROTL/CMP).
// Latency: done in the cycle after the accepting edge; WIDTH+1 cycles for the iterative multiply.
// Backpressure: start is accepted only while busy=0; a start seen while busy is dropped, never queued.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start, sel[2:0], r0, r1   request strobe, op select and operands (latched on the accepting edge)
//   r2                        registered result, held until the next op completes
//   overflow, borrowflag, zero  registered flags for the last completed op
//   busy, done                busy = not idle; done = one-cycle completion pulse
//
// Build option: define ALU_MUL_EN to get the multi-cycle shift-add multiply on sel=110;
// without it sel=110 is a single-cycle rotate-left by r1[SHW-1:0].
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic             overflow,
    output logic             borrowflag,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    logic [1:0] state;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated straight off the request inputs so
    // the result can be registered on the accepting edge itself.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic [2*WIDTH-1:0]   shl_full;

    assign add_full = {1'b0, r0} + {1'b0, r1};
    // Top bit of the (WIDTH+1)-bit difference is set exactly when r0 < r1.
    assign sub_full = {1'b0, r0} - {1'b0, r1};
    // Upper half collects the bits pushed out of the WIDTH-bit window; a
    // shift of 0 leaves it empty, so overflow falls out as 0 naturally.
    assign shl_full = {{WIDTH{1'b0}}, r0} << r1[SHW-1:0];

    logic [WIDTH-1:0] alu_res;   // value used for r2 and the zero flag
    logic             alu_wr;    // CMP leaves r2 untouched
    logic             alu_ov;
    logic             alu_bf;

    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b1;
        alu_ov  = 1'b0;
        alu_bf  = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_ov  = add_full[WIDTH];
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_bf  = sub_full[WIDTH];
            end
            OP_AND: alu_res = r0 & r1;
            OP_OR:  alu_res = r0 | r1;
            OP_XOR: alu_res = r0 ^ r1;
            OP_SHL: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_ov  = |shl_full[2*WIDTH-1:WIDTH];
            end
            // Rotate = bits kept in the window OR'd with the bits shifted out.
            // With the multiplier built this leg is never committed.
            OP_MUL: alu_res = shl_full[WIDTH-1:0] | shl_full[2*WIDTH-1:WIDTH];
            OP_CMP: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_bf  = sub_full[WIDTH];
                alu_wr  = 1'b0;
            end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier: one multiplier bit per cycle, LSB
    // first. The multiplicand walks left through a 2*WIDTH register.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod_next;

    assign prod_next = prod + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            r2         <= '0;
            overflow   <= 1'b0;
            borrowflag <= 1'b0;
            zero       <= 1'b0;
            done       <= 1'b0;
`ifdef ALU_MUL_EN
            mcand      <= '0;
            prod       <= '0;
            mplier     <= '0;
            cnt        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef ALU_MUL_EN
                        if (sel == OP_MUL) begin
                            state  <= S_MUL;
                            mcand  <= {{WIDTH{1'b0}}, r0};
                            mplier <= r1;
                            prod   <= '0;
                            cnt    <= '0;
                        end else
`endif
                        begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            overflow   <= alu_ov;
                            borrowflag <= alu_bf;
                            zero       <= (alu_res == '0);
                            if (alu_wr) begin
                                r2 <= alu_res;
                            end
                        end
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last partial product lands here; commit the sum directly
                    // rather than spending another cycle re-reading prod.
                    if (cnt == CNT_LAST) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        r2         <= prod_next[WIDTH-1:0];
                        overflow   <= |prod_next[2*WIDTH-1:WIDTH];
                        borrowflag <= 1'b0;
                        zero       <= (prod_next[WIDTH-1:0] == '0);
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Purpose: self-checking bench for alu_seq (WIDTH=8) using a directed vector table plus corner sequences.
// Latency: checks done arrives 1 cycle after accept (WIDTH+1 for the multiply build).
// Backpressure: exercises starts issued while busy, reset mid-operation and reset coinciding with start.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] sel = 3'b000;
    logic [7:0] r0 = 8'h00;
    logic [7:0] r1 = 8'h00;
    logic [7:0] r2;
    logic       overflow;
    logic       borrowflag;
    logic       zero;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8), .SHW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sel        (sel),
        .r0         (r0),
        .r1         (r1),
        .r2         (r2),
        .overflow   (overflow),
        .borrowflag (borrowflag),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r2;
        logic       ov;
        logic       bf;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er2, input logic eov, input logic ebf, input logic ez,
                           input int lat);
        vec_t v;
        v.name = nm; v.sel = s; v.a = a; v.b = b;
        v.r2 = er2; v.ov = eov; v.bf = ebf; v.z = ez; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency, result and the return to idle.
    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        start = 1'b1; sel = v.sel; r0 = v.a; r1 = v.b;
        @(posedge clk); #1;
        // Operands are latched, so scramble the inputs once accepted.
        start = 1'b0; sel = 3'($urandom); r0 = 8'($urandom); r1 = 8'($urandom);
        check({v.name, " busy"}, 32'(busy), 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({v.name, " latency"}, 32'(n), 32'(v.lat));
        check({v.name, " r2"}, 32'(r2), 32'(v.r2));
        check({v.name, " overflow"}, 32'(overflow), 32'(v.ov));
        check({v.name, " borrowflag"}, 32'(borrowflag), 32'(v.bf));
        check({v.name, " zero"}, 32'(zero), 32'(v.z));
        @(posedge clk); #1;
        check({v.name, " done pulse width"}, 32'(done), 32'd0);
        check({v.name, " idle after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;

        // ---------------- vector table ----------------
        add_vec("ADD",        3'b000, 8'h6A, 8'hE2, 8'h4C, 1'b1, 1'b0, 1'b0, 1);
        add_vec("ADD wrap0",  3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        add_vec("SUB",        3'b001, 8'h6A, 8'hE2, 8'h88, 1'b0, 1'b1, 1'b0, 1);
        add_vec("SUB eq",     3'b001, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1, 1);
        add_vec("AND",        3'b010, 8'h6A, 8'hE2, 8'h62, 1'b0, 1'b0, 1'b0, 1);
        add_vec("OR",         3'b011, 8'h6A, 8'hE2, 8'hEA, 1'b0, 1'b0, 1'b0, 1);
        add_vec("XOR",        3'b100, 8'h6A, 8'hE2, 8'h88, 1'b0, 1'b0, 1'b0, 1);
        add_vec("SHL2",       3'b101, 8'h6A, 8'hE2, 8'hA8, 1'b1, 1'b0, 1'b0, 1);
        add_vec("CMP eq",     3'b111, 8'h55, 8'h55, 8'hA8, 1'b0, 1'b0, 1'b1, 1);
        add_vec("CMP lt",     3'b111, 8'h6A, 8'hE2, 8'hA8, 1'b0, 1'b1, 1'b0, 1);
        add_vec("SHL0",       3'b101, 8'hFF, 8'hF8, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
`ifdef ALU_MUL_EN
        add_vec("MUL",        3'b110, 8'h6A, 8'hE2, 8'h94, 1'b1, 1'b0, 1'b0, 9);
        add_vec("MUL small",  3'b110, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0, 1'b0, 9);
        add_vec("MUL zero",   3'b110, 8'h00, 8'hE2, 8'h00, 1'b0, 1'b0, 1'b1, 9);
`else
        add_vec("ROTL2",      3'b110, 8'h6A, 8'hE2, 8'hA9, 1'b0, 1'b0, 1'b0, 1);
        add_vec("ROTL5",      3'b110, 8'h03, 8'h05, 8'h60, 1'b0, 1'b0, 1'b0, 1);
        add_vec("ROTL0",      3'b110, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0, 1);
`endif

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset r2", 32'(r2), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset borrowflag", 32'(borrowflag), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // ---------------- start held into the DONE cycle is ignored ----------------
        @(negedge clk);
        start = 1'b1; sel = 3'b000; r0 = 8'h6A; r1 = 8'hE2;
        @(posedge clk); #1;
        check("held start done", 32'(done), 32'd1);
        sel = 3'b001; r0 = 8'h01; r1 = 8'h02;   // start stays high across the DONE edge
        @(posedge clk); #1;
        start = 1'b0;
        check("held start idle", 32'(busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) dcount++;
            @(posedge clk); #1;
        end
        check("held start extra done", 32'(dcount), 32'd0);
        check("held start r2", 32'(r2), 32'h4C);

`ifdef ALU_MUL_EN
        // ---------------- start pulse during MUL is ignored ----------------
        @(negedge clk);
        start = 1'b1; sel = 3'b110; r0 = 8'h6A; r1 = 8'hE2;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        for (int i = 1; i <= 20; i++) begin
            if (done === 1'b1) dcount++;
            if (i == 3) begin start = 1'b1; sel = 3'b000; r0 = 8'h01; r1 = 8'h01; end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
        end
        check("mul busy start dones", 32'(dcount), 32'd1);
        check("mul busy start r2", 32'(r2), 32'h94);
        check("mul busy start overflow", 32'(overflow), 32'd1);

        // ---------------- reset at cycle 4 of MUL ----------------
        @(negedge clk);
        start = 1'b1; sel = 3'b110; r0 = 8'h03; r1 = 8'h05;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`else
        // ---------------- reset in the DONE cycle ----------------
        @(negedge clk);
        start = 1'b1; sel = 3'b000; r0 = 8'h6A; r1 = 8'hE2;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        check("abort r2", 32'(r2), 32'd0);
        check("abort overflow", 32'(overflow), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dcount++;
            @(posedge clk); #1;
        end
        check("abort late done", 32'(dcount), 32'd0);

        // ---------------- start and rst together: rst wins ----------------
        run_op(vecs[0]);   // leave a non-zero r2 behind
        @(negedge clk);
        rst = 1'b1; start = 1'b1; sel = 3'b000; r0 = 8'h01; r1 = 8'h02;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", 32'(busy), 32'd0);
        check("rst+start done", 32'(done), 32'd0);
        check("rst+start r2", 32'(r2), 32'd0);
        @(posedge clk); #1;
        check("rst+start no later done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
